// File: rtl/rx_pkg.sv
// Shared types for the block extractor: header codes, block record and
// extractor state encoding.
package rx_pkg;

  localparam logic [1:0] c_DATA_HEADER = 2'b01;
  localparam logic [1:0] c_CMD_HEADER  = 2'b10;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } block_t;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } ext_state_e;

  function automatic logic hdr_valid(input logic [1:0] h);
    return (h == c_DATA_HEADER) || (h == c_CMD_HEADER);
  endfunction

endpackage

// File: rtl/block_extractor_if.sv
// Output block stream: header/payload with valid/ready handshake.
// master drives hdr/data/valid and samples ready; slave is the consumer.
interface block_extractor_if;

  logic [1:0]  blk_hdr_o;
  logic [63:0] blk_data_o;
  logic        blk_valid_o;
  logic        blk_ready_i;

  modport master (
    output blk_hdr_o,
    output blk_data_o,
    output blk_valid_o,
    input  blk_ready_i
  );

  modport slave (
    input  blk_hdr_o,
    input  blk_data_o,
    input  blk_valid_o,
    output blk_ready_i
  );

endinterface

// File: rtl/blk_fifo.sv
// First-word fall-through block FIFO. Ports: clk_i, rst_ni, push/wdata,
// pop/rdata, full, empty. Push while full is accepted only with a pop.
module blk_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             wr;
  logic             rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);

  // Empty FIFO presents zeros rather than stale storage.
  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/block_extractor.sv
// Extracts 66-bit blocks from the gearbox buffer, tracks lock, queues blocks.
// Ports: clk_i, rst_ni, gbox_buffer/gbox_cnt/buffer_dv, block_offset,
// is_synced, blk (stream master), locked_o, hdr_err_cnt_o,
// sync_loss_cnt_o, ovf_o. Option: BLOCK_EXTRACTOR_DESCRAMBLE_EN adds an
// x^58+x^39+1 self-synchronous payload descrambler ahead of the FIFO.
module block_extractor #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [193:0] gbox_buffer,
  input  logic [5:0]   gbox_cnt,
  input  logic         buffer_dv,
  input  logic [6:0]   block_offset,
  input  logic         is_synced,
  block_extractor_if.master blk,
  output logic         locked_o,
  output logic [7:0]   hdr_err_cnt_o,
  output logic [7:0]   sync_loss_cnt_o,
  output logic         ovf_o
);

  import rx_pkg::*;

  localparam logic [0:0] HUNT = ST_HUNT;
  localparam logic [0:0] LOCK = ST_LOCK;

  logic [193:0] buf_q;
  logic [193:0] buf_qq;
  logic [5:0]   cnt_q;
  logic [5:0]   cnt_qq;
  logic         ext_pulse;

  logic [8:0]   idx;
  logic [8:0]   lo;
  block_t       raw;
  block_t       blk_in;
  block_t       blk_out;

  logic [0:0]   state_q;
  logic [0:0]   state_d;
  logic         push;
  logic         pop;
  logic         hdr_err;
  logic         sync_loss;
  logic         full;
  logic         empty;

  // Two-deep buffer history: the aligner offset refers to the previous dv.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q     <= '0;
      buf_qq    <= '0;
      cnt_q     <= '0;
      cnt_qq    <= '0;
      ext_pulse <= 1'b0;
    end else begin
      ext_pulse <= buffer_dv;
      if (buffer_dv) begin
        buf_q  <= gbox_buffer;
        cnt_q  <= gbox_cnt;
        buf_qq <= buf_q;
        cnt_qq <= cnt_q;
      end
    end
  end

  // Block MSB sits at idx; shift so the block's LSB lands at bit 0.
  assign idx = 9'd128 - 9'(cnt_qq) + 9'(block_offset);
  assign lo  = idx - 9'd65;
  assign raw = block_t'(66'({62'b0, buf_qq} >> lo));

`ifdef BLOCK_EXTRACTOR_DESCRAMBLE_EN
  logic [57:0] dsc_q;
  logic [57:0] dsc_s;
  logic [63:0] dsc_data;

  // Bit 0 is first on the wire; state holds received scrambled bits.
  always_comb begin
    dsc_s    = dsc_q;
    dsc_data = '0;
    for (int i = 0; i < 64; i++) begin
      dsc_data[i] = raw.data[i] ^ dsc_s[38] ^ dsc_s[57];
      dsc_s       = {dsc_s[56:0], raw.data[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dsc_q <= '0;
    else if (ext_pulse) dsc_q <= dsc_s;
  end

  assign blk_in = '{hdr: raw.hdr, data: dsc_data};
`else
  assign blk_in = raw;
`endif

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    hdr_err   = 1'b0;
    sync_loss = 1'b0;
    if (ext_pulse) begin
      unique case (1'b1)
        (state_q == HUNT): begin
          if (is_synced) begin
            state_d = LOCK;
            push    = hdr_valid(blk_in.hdr);
          end
        end
        (state_q == LOCK): begin
          if (!is_synced) begin
            state_d   = HUNT;
            sync_loss = 1'b1;
          end else if (hdr_valid(blk_in.hdr)) begin
            push = 1'b1;
          end else begin
            hdr_err = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign pop = !empty && blk.blk_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= HUNT;
      hdr_err_cnt_o   <= '0;
      sync_loss_cnt_o <= '0;
      ovf_o           <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hdr_err && hdr_err_cnt_o != 8'hFF)
        hdr_err_cnt_o <= hdr_err_cnt_o + 8'd1;
      if (sync_loss && sync_loss_cnt_o != 8'hFF)
        sync_loss_cnt_o <= sync_loss_cnt_o + 8'd1;
      if (push && full && !pop)
        ovf_o <= 1'b1;
    end
  end

  assign locked_o = (state_q == LOCK);

  blk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(block_t))
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (blk_in),
    .pop    (pop),
    .rdata  (blk_out),
    .full   (full),
    .empty  (empty)
  );

  assign blk.blk_valid_o = !empty;
  assign blk.blk_hdr_o   = blk_out.hdr;
  assign blk.blk_data_o  = blk_out.data;

endmodule

// File: doc/block_extractor.md
BLOCK_EXTRACTOR -- requirements
Module: block_extractor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 SHALL have ports: clk_i  in  1  system clock; rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have ports: gbox_buffer  in  194  gearbox buffer; gbox_cnt  in  6  window index; buffer_dv  in  1  buffer valid.
REQ-004 SHALL have ports: block_offset  in  7  header offset from aligner; is_synced  in  1  aligner sync flag.
REQ-005 SHALL have ports: blk_hdr_o  out  2  block header; blk_data_o  out  64  block payload; blk_valid_o  out  1; blk_ready_i  in  1.
REQ-006 SHALL have ports: locked_o  out  1; hdr_err_cnt_o  out  8; sync_loss_cnt_o  out  8; ovf_o  out  1  sticky overflow.

Function
REQ-007 On buffer_dv: buf_q<=gbox_buffer, cnt_q<=gbox_cnt, buf_qq<=buf_q, cnt_qq<=cnt_q; ext_pulse<=buffer_dv, registered one cycle.
REQ-008 On ext_pulse, block = buf_qq[128-cnt_qq+block_offset -: 66]; header = top 2 bits, data = low 64; this matches the aligner's one-dv offset latency.
REQ-009 FSM states HUNT, LOCK; reset state HUNT; locked_o=1 only in LOCK.
REQ-010 HUNT->LOCK on ext_pulse with is_synced=1; that block is extracted.
REQ-011 LOCK->HUNT on ext_pulse with is_synced=0; no block pushed; sync_loss_cnt increments, saturating at 255.
REQ-012 In LOCK on ext_pulse: header 01 or 10 -> push {hdr,data} into FIFO; header 00/11 -> drop, hdr_err_cnt increments, saturating at 255.
REQ-013 HUNT SHALL push nothing and SHALL not count header errors.
REQ-014 FIFO SHALL be FIFO_DEPTH deep, first-word fall-through; blk_valid_o = !empty; pop when blk_valid_o && blk_ready_i.
REQ-015 Push while full SHALL drop the new block, keep FIFO contents, set ovf_o until reset.
REQ-016 Push and pop in the same cycle while full SHALL accept both, with no overflow.
REQ-017 Outputs blk_hdr_o/blk_data_o SHALL hold stable while blk_valid_o=1 and blk_ready_i=0.
REQ-018 Push latency: block visible on blk_valid_o the cycle after ext_pulse when FIFO empty.

Reset
REQ-019 rst_ni low, asynchronously: FSM=HUNT, FIFO empty, blk_valid_o=0, blk_hdr_o=0, blk_data_o=0, locked_o=0, counters=0, ovf_o=0, ext_pulse=0, buf/cnt regs=0.
REQ-020 Reset mid-operation SHALL discard FIFO contents and any in-flight ext_pulse.

Configuration
REQ-021 Macro BLOCK_EXTRACTOR_DESCRAMBLE_EN defined: payload descrambled by self-synchronous x^58+x^39+1 descrambler before the FIFO; it runs on every ext_pulse.
REQ-022 Macro BLOCK_EXTRACTOR_DESCRAMBLE_EN defined: descrambler state = last 58 received scrambled bits; it resets to 0 and resynchronises on its own after 58 bits.
REQ-023 Macro BLOCK_EXTRACTOR_DESCRAMBLE_EN undefined: payload passes raw; no descrambler logic is present.

Structure
REQ-024 Package rx_pkg SHALL hold c_DATA_HEADER=2'b01, c_CMD_HEADER=2'b10, block_t {hdr[1:0], data[63:0]}, and extractor state enum.
REQ-025 FIFO SHALL be sub-module blk_fifo (parameterised depth, width of block_t).

Verification
REQ-026 Reset, then is_synced=1, offset=5, buffer with header 01 at the REQ-008 slice -> blk_valid_o=1, blk_hdr_o=01, data matches; locked_o=1.
REQ-027 While locked, inject header 11 -> no push, hdr_err_cnt_o=1; 256 such blocks -> hdr_err_cnt_o stays 255.
REQ-028 is_synced drops on an ext_pulse -> locked_o=0 next cycle, sync_loss_cnt_o=1, no further pushes until is_synced=1.
REQ-029 blk_ready_i=0, 5 valid blocks, FIFO_DEPTH=4 -> 4 stored, ovf_o=1; ready=1 -> the first 4 blocks are output in order.
REQ-030 Full FIFO, push and pop in the same cycle -> no overflow, count unchanged.
REQ-031 With DESCRAMBLE_EN: scrambled known sequence fed -> plaintext recovered from the second block onward.
